// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER run controller.
// The optional BER_SNAPSHOT_EN build adds coherent snapshot registers in ber_run_ctrl.
package ber_pkg;

   localparam int CNT_W_DFLT = 64;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      STOP_NONE  = 2'd0,
      STOP_FERR  = 2'd1,
      STOP_FMAX  = 2'd2,
      STOP_ABORT = 2'd3
   } stop_reason_t;

   // Width needed to sum n values of w bits without overflow.
   function automatic int sum_w(input int n, input int w);
      return w + $clog2(n);
   endfunction

endpackage

// File: rtl/ber_run_ctrl_if.sv
// Core-side bundle: enable/clear towards the BER cores, per-cycle increments back.
interface ber_run_ctrl_if #(
   parameter int N_CORES = 10,
   parameter int INC_W   = 8
);
   logic                            core_en;
   logic                            core_clr;
   logic [N_CORES-1:0][INC_W-1:0]   core_bits;
   logic [N_CORES-1:0][INC_W-1:0]   core_bit_err_pre;
   logic [N_CORES-1:0][INC_W-1:0]   core_bit_err_post;
   logic [N_CORES-1:0]              core_frame_done;
   logic [N_CORES-1:0]              core_frame_err;

   modport master (
      output core_en, core_clr,
      input  core_bits, core_bit_err_pre, core_bit_err_post,
             core_frame_done, core_frame_err
   );

   modport slave (
      input  core_en, core_clr,
      output core_bits, core_bit_err_pre, core_bit_err_post,
             core_frame_done, core_frame_err
   );
endinterface

// File: rtl/ber_sum_tree.sv
// Registered N-input reduction: sums N W-bit lanes (W=1 gives a popcount).
// Non-accepted cycles register zero, so the consumer can add unconditionally.
module ber_sum_tree import ber_pkg::*; #(
   parameter  int N  = 10,
   parameter  int W  = 8,
   localparam int SW = sum_w(N, W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           vld,
   input  logic [N*W-1:0] din,
   output logic [SW-1:0]  sum
);

   logic [SW-1:0] acc;

   // Combinational adder chain across all lanes.
   always_comb begin
      acc = '0;
      for (int i = 0; i < N; i++)
         acc = acc + SW'(din[i*W +: W]);
   end

   // Stage-1 register; flushed on reset or run clear.
   always_ff @(posedge clk) begin
      if (rst || clr)
         sum <= '0;
      else if (vld)
         sum <= acc;
      else
         sum <= '0;
   end

endmodule

// File: rtl/ber_run_ctrl.sv
// BER run controller: clears/enables the cores, aggregates per-core increments
// into saturating totals and ends the run on frame-error target, frame limit
// or abort. Define BER_SNAPSHOT_EN to add snap_req / snap_valid / snap_total_*.
module ber_run_ctrl import ber_pkg::*; #(
   parameter int N_CORES   = 10,
   parameter int INC_W     = 8,
   parameter int CNT_W     = CNT_W_DFLT,
   parameter int DRAIN_CYC = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   target_frame_errors,
   input  logic [CNT_W-1:0]   max_frames,
`ifdef BER_SNAPSHOT_EN
   input  logic               snap_req,
   output logic               snap_valid,
   output logic [CNT_W-1:0]   snap_total_bits,
   output logic [CNT_W-1:0]   snap_total_bit_errors_pre,
   output logic [CNT_W-1:0]   snap_total_bit_errors_post,
   output logic [CNT_W-1:0]   snap_total_frames,
   output logic [CNT_W-1:0]   snap_total_frame_errors,
`endif
   ber_run_ctrl_if.master     cores,
   output logic               busy,
   output logic               done,
   output logic [1:0]         stop_reason,
   output logic [CNT_W-1:0]   total_bits,
   output logic [CNT_W-1:0]   total_bit_errors_pre,
   output logic [CNT_W-1:0]   total_bit_errors_post,
   output logic [CNT_W-1:0]   total_frames,
   output logic [CNT_W-1:0]   total_frame_errors
);

   localparam int SW = sum_w(N_CORES, INC_W);
   localparam int FW = sum_w(N_CORES, 1);
   localparam int AW = ((CNT_W > SW) ? CNT_W : SW) + 1;
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam logic [AW-1:0] SAT_MAX = AW'({CNT_W{1'b1}});

   state_t         state;
   stop_reason_t   reason;
   logic [DW-1:0]  drain_cnt;
   logic           en_q, clr_q;
   logic           accept, tot_clr;
   logic           ferr_hit, fmax_hit;
   logic [SW-1:0]  s_bits, s_pre, s_post;
   logic [FW-1:0]  s_frm, s_ferr;

   assign accept   = (state == RUN) || (state == DRAIN);
   assign tot_clr  = start && ((state == IDLE) || (state == DONE));
   assign ferr_hit = (target_frame_errors != '0) && (total_frame_errors >= target_frame_errors);
   assign fmax_hit = (max_frames != '0) && (total_frames >= max_frames);

   assign cores.core_en  = en_q;
   assign cores.core_clr = clr_q;
   assign stop_reason    = reason;

   ber_sum_tree #(.N(N_CORES), .W(INC_W)) u_sum_bits (
      .clk(clk), .rst(rst), .clr(tot_clr), .vld(accept),
      .din(cores.core_bits), .sum(s_bits));

   ber_sum_tree #(.N(N_CORES), .W(INC_W)) u_sum_pre (
      .clk(clk), .rst(rst), .clr(tot_clr), .vld(accept),
      .din(cores.core_bit_err_pre), .sum(s_pre));

   ber_sum_tree #(.N(N_CORES), .W(INC_W)) u_sum_post (
      .clk(clk), .rst(rst), .clr(tot_clr), .vld(accept),
      .din(cores.core_bit_err_post), .sum(s_post));

   ber_sum_tree #(.N(N_CORES), .W(1)) u_sum_frm (
      .clk(clk), .rst(rst), .clr(tot_clr), .vld(accept),
      .din(cores.core_frame_done), .sum(s_frm));

   // A frame error only counts when the same core also reports the frame done.
   ber_sum_tree #(.N(N_CORES), .W(1)) u_sum_ferr (
      .clk(clk), .rst(rst), .clr(tot_clr), .vld(accept),
      .din(cores.core_frame_done & cores.core_frame_err), .sum(s_ferr));

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [SW-1:0]    b);
      logic [AW-1:0] s;
      s = AW'(a) + AW'(b);
      return (s > SAT_MAX) ? '1 : s[CNT_W-1:0];
   endfunction

   // Stage 2: fold the registered per-cycle sums into clamped totals.
   // Zeroed on the start edge so totals already read 0 while core_clr is high.
   always_ff @(posedge clk) begin
      if (rst || tot_clr) begin
         total_bits            <= '0;
         total_bit_errors_pre  <= '0;
         total_bit_errors_post <= '0;
         total_frames          <= '0;
         total_frame_errors    <= '0;
      end else begin
         total_bits            <= sat_add(total_bits, s_bits);
         total_bit_errors_pre  <= sat_add(total_bit_errors_pre, s_pre);
         total_bit_errors_post <= sat_add(total_bit_errors_post, s_post);
         total_frames          <= sat_add(total_frames, SW'(s_frm));
         total_frame_errors    <= sat_add(total_frame_errors, SW'(s_ferr));
      end
   end

   // Run FSM with registered outputs. The last drained cycle lands in the
   // totals one cycle after done rises.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         reason    <= STOP_NONE;
         drain_cnt <= '0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         clr_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= CLEAR;
                  reason <= STOP_NONE;
                  clr_q  <= 1'b1;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            CLEAR: begin
               state <= RUN;
               en_q  <= 1'b1;
            end
            RUN: begin
               if (abort || ferr_hit || fmax_hit) begin
                  state     <= DRAIN;
                  en_q      <= 1'b0;
                  drain_cnt <= '0;
                  reason    <= abort ? STOP_ABORT : (ferr_hit ? STOP_FERR : STOP_FMAX);
               end
            end
            DRAIN: begin
               if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BER_SNAPSHOT_EN
   // Atomic copy of all totals as seen in the request cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_valid                 <= 1'b0;
         snap_total_bits            <= '0;
         snap_total_bit_errors_pre  <= '0;
         snap_total_bit_errors_post <= '0;
         snap_total_frames          <= '0;
         snap_total_frame_errors    <= '0;
      end else begin
         snap_valid <= snap_req;
         if (snap_req) begin
            snap_total_bits            <= total_bits;
            snap_total_bit_errors_pre  <= total_bit_errors_pre;
            snap_total_bit_errors_post <= total_bit_errors_post;
            snap_total_frames          <= total_frames;
            snap_total_frame_errors    <= total_frame_errors;
         end
      end
   end
`endif

endmodule
